// File: rtl/ifu_line_responder.sv
// ifu_line_responder: memory-side responder for the IFU fetch port.
// Serves one 16-byte line per request as two 8-byte backing-memory beats
// and answers with a one-cycle ready pulse (err flags writes/out-of-range).
// Optional one-entry line buffer enabled by defining IFU_LINE_BUF_EN.
module ifu_line_responder #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] MEM_BASE = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 64'h0800_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rw_addr_i,
    input  logic              i_rw_req_i,
    input  logic              i_rw_valid_i,
    output logic [127:0]      i_data_read_o,
    output logic              i_rw_ready_o,
    output logic              i_rw_err_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic              mem_rvalid_o,
    input  logic [63:0]       mem_rdata_i,
    input  logic              mem_rready_i
);

    typedef enum logic [1:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RESP
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] line_q;
    logic [63:0]       lo_q;
    logic              abort_q;
    logic [127:0]      data_q;
    logic              ready_q;
    logic              err_q;
    logic [ADDR_W-1:0] raddr_q;
    logic              rvalid_q;

    logic [ADDR_W-1:0] req_line;
    logic [ADDR_W:0]   range_lim;
    logic [ADDR_W:0]   line_last;
    logic              req_legal;
    logic              unused_addr_lo;

    assign req_line       = {i_rw_addr_i[ADDR_W-1:4], 4'b0000};
    assign unused_addr_lo = ^i_rw_addr_i[3:0];

    // Extra top bit keeps base+size and line+15 from wrapping, so a line
    // touching the top of the address space is judged correctly.
    assign range_lim = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    assign line_last = {1'b0, req_line} + (ADDR_W+1)'(15);
    assign req_legal = (req_line >= MEM_BASE) && (line_last < range_lim);

`ifdef IFU_LINE_BUF_EN
    logic [ADDR_W-1:0] buf_tag_q;
    logic [127:0]      buf_data_q;
    logic              buf_valid_q;
    logic              buf_hit;

    assign buf_hit = buf_valid_q && (buf_tag_q == req_line);
`endif

    assign i_data_read_o = data_q;
    assign i_rw_ready_o  = ready_q;
    assign i_rw_err_o    = err_q;
    assign mem_raddr_o   = raddr_q;
    assign mem_rvalid_o  = rvalid_q;

    // Request FSM with registered response and backing-read outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            line_q      <= '0;
            lo_q        <= '0;
            abort_q     <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            raddr_q     <= '0;
            rvalid_q    <= 1'b0;
`ifdef IFU_LINE_BUF_EN
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_rw_valid_i) begin
                        line_q  <= req_line;
                        abort_q <= 1'b0;
                        if (i_rw_req_i || !req_legal) begin
`ifdef IFU_LINE_BUF_EN
                            if (i_rw_req_i && (buf_tag_q == req_line)) begin
                                buf_valid_q <= 1'b0;
                            end
`endif
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            data_q  <= '0;
                        end
`ifdef IFU_LINE_BUF_EN
                        else if (buf_hit) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b0;
                            data_q  <= buf_data_q;
                        end
`endif
                        else begin
                            state_q  <= RD_LO;
                            rvalid_q <= 1'b1;
                            raddr_q  <= req_line;
                        end
                    end
                end
                RD_LO: begin
                    if (!i_rw_valid_i) begin
                        abort_q <= 1'b1;
                    end
                    if (mem_rready_i) begin
                        lo_q    <= mem_rdata_i;
                        raddr_q <= line_q + ADDR_W'(8);
                        state_q <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (mem_rready_i) begin
                        rvalid_q <= 1'b0;
                        abort_q  <= 1'b0;
`ifdef IFU_LINE_BUF_EN
                        buf_tag_q   <= line_q;
                        buf_data_q  <= {mem_rdata_i, lo_q};
                        buf_valid_q <= 1'b1;
`endif
                        // A flush seen on the completing cycle also suppresses the pulse.
                        if (abort_q || !i_rw_valid_i) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b0;
                            data_q  <= {mem_rdata_i, lo_q};
                        end
                    end else if (!i_rw_valid_i) begin
                        abort_q <= 1'b1;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_line_responder.sv
// Directed self-checking bench for ifu_line_responder.
// Honours IFU_LINE_BUF_EN to select buffered-refetch expectations.
module tb_ifu_line_responder;

    logic         clk;
    logic         rst;
    logic [63:0]  i_rw_addr_i;
    logic         i_rw_req_i;
    logic         i_rw_valid_i;
    logic [127:0] i_data_read_o;
    logic         i_rw_ready_o;
    logic         i_rw_err_o;
    logic [63:0]  mem_raddr_o;
    logic         mem_rvalid_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_rready_i;

    int n_cmp  = 0;
    int n_fail = 0;

    int mem_delay    = 0;
    int wait_cnt     = 0;
    int beats        = 0;
    int ready_cnt    = 0;
    int rvalid_cnt   = 0;
    int unstable_cnt = 0;
    logic        prev_rvalid = 1'b0;
    logic        prev_rready = 1'b0;
    logic [63:0] prev_raddr  = '0;

    ifu_line_responder #(
        .ADDR_W   (64),
        .MEM_BASE (64'h8000_0000),
        .MEM_SIZE (64'h0800_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rw_addr_i   (i_rw_addr_i),
        .i_rw_req_i    (i_rw_req_i),
        .i_rw_valid_i  (i_rw_valid_i),
        .i_data_read_o (i_data_read_o),
        .i_rw_ready_o  (i_rw_ready_o),
        .i_rw_err_o    (i_rw_err_o),
        .mem_raddr_o   (mem_raddr_o),
        .mem_rvalid_o  (mem_rvalid_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rready_i  (mem_rready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h1111;
        if (a == 64'h8000_0008) return 64'h2222;
        return {~a[31:0], a[31:0]};
    endfunction

    // Backing memory with programmable wait states, plus activity monitors.
    always @(negedge clk) begin
        if (prev_rvalid && !prev_rready && mem_rvalid_o && rst && (mem_raddr_o !== prev_raddr))
            unstable_cnt++;
        if (i_rw_ready_o) ready_cnt++;
        if (mem_rvalid_o) rvalid_cnt++;
        if (mem_rvalid_o && rst) begin
            if (wait_cnt >= mem_delay) begin
                mem_rready_i = 1'b1;
                mem_rdata_i  = mem_word(mem_raddr_o);
                wait_cnt     = 0;
                beats++;
            end else begin
                mem_rready_i = 1'b0;
                mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            mem_rready_i = 1'b0;
            mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
            wait_cnt     = 0;
        end
        prev_rvalid = mem_rvalid_o;
        prev_rready = mem_rready_i;
        prev_raddr  = mem_raddr_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issue one request from a negedge; lat counts negedges after the accepting edge (-1 = timeout).
    task automatic do_req(input logic [63:0] a, input logic rq,
                          output int lat, output logic [127:0] d, output logic e);
        i_rw_addr_i  = a;
        i_rw_req_i   = rq;
        i_rw_valid_i = 1'b1;
        lat = -1;
        d   = '0;
        e   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_rw_ready_o) begin
                lat = k;
                d   = i_rw_read_data();
                e   = i_rw_err_o;
                break;
            end
        end
        i_rw_valid_i = 1'b0;
        i_rw_req_i   = 1'b0;
    endtask

    function automatic logic [127:0] i_rw_read_data();
        return i_data_read_o;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        i_rw_addr_i = '0; i_rw_req_i = 1'b0; i_rw_valid_i = 1'b0;
        mem_rready_i = 1'b0; mem_rdata_i = '0;
        #1;
        n_cmp++; if (i_rw_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", i_rw_ready_o); end
        n_cmp++; if (i_rw_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", i_rw_err_o); end
        n_cmp++; if (i_data_read_o !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", i_data_read_o); end
        n_cmp++; if (mem_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", mem_rvalid_o); end
        n_cmp++; if (mem_raddr_o !== 64'h0) begin n_fail++; $display("FAIL reset_raddr: got %h want 0", mem_raddr_o); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_miss();
        mem_delay = 0;
        i_rw_addr_i = 64'h8000_0004; i_rw_req_i = 1'b0; i_rw_valid_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL miss_rvalid_lo: got %b want 1", mem_rvalid_o); end
        n_cmp++; if (mem_raddr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL miss_raddr_lo: got %h want 80000000", mem_raddr_o); end
        @(negedge clk);
        n_cmp++; if (mem_raddr_o !== 64'h8000_0008) begin n_fail++; $display("FAIL miss_raddr_hi: got %h want 80000008", mem_raddr_o); end
        n_cmp++; if (i_rw_ready_o !== 1'b0) begin n_fail++; $display("FAIL miss_early_ready: got %b want 0", i_rw_ready_o); end
        @(negedge clk);
        n_cmp++; if (i_rw_ready_o !== 1'b1) begin n_fail++; $display("FAIL miss_ready: got %b want 1", i_rw_ready_o); end
        n_cmp++; if (i_data_read_o !== 128'h0000_0000_0000_2222_0000_0000_0000_1111) begin n_fail++; $display("FAIL miss_data: got %h want 2222/1111", i_data_read_o); end
        n_cmp++; if (i_rw_err_o !== 1'b0) begin n_fail++; $display("FAIL miss_err: got %b want 0", i_rw_err_o); end
        i_rw_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (i_rw_ready_o !== 1'b0) begin n_fail++; $display("FAIL miss_ready_one_cycle: got %b want 0", i_rw_ready_o); end
        n_cmp++; if (i_data_read_o !== 128'h0000_0000_0000_2222_0000_0000_0000_1111) begin n_fail++; $display("FAIL miss_data_hold: got %h want 2222/1111", i_data_read_o); end
        n_cmp++; if (mem_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL miss_rvalid_idle: got %b want 0", mem_rvalid_o); end
    endtask

    task automatic test_slow_mem();
        int lat; logic [127:0] d; logic e; int r0; int u0;
        mem_delay = 3;
        r0 = ready_cnt; u0 = unstable_cnt;
        do_req(64'h8000_0020, 1'b0, lat, d, e);
        repeat (4) @(negedge clk);
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL slow_latency: got %0d want 8", lat); end
        n_cmp++; if (d !== {64'h7FFF_FFD7_8000_0028, 64'h7FFF_FFDF_8000_0020}) begin n_fail++; $display("FAIL slow_data: got %h", d); end
        n_cmp++; if (ready_cnt - r0 !== 1) begin n_fail++; $display("FAIL slow_pulses: got %0d want 1", ready_cnt - r0); end
        n_cmp++; if (unstable_cnt - u0 !== 0) begin n_fail++; $display("FAIL slow_raddr_stable: got %0d changes want 0", unstable_cnt - u0); end
        mem_delay = 0;
    endtask

    task automatic test_error();
        int lat; logic [127:0] d; logic e; int v0;
        mem_delay = 0;
        v0 = rvalid_cnt;
        do_req(64'h8000_0000, 1'b1, lat, d, e);
        n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL err_write_latency: got %0d want 0", lat); end
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_write_err: got %b want 1", e); end
        n_cmp++; if (d !== 128'h0) begin n_fail++; $display("FAIL err_write_data: got %h want 0", d); end
        @(negedge clk);
        n_cmp++; if (i_rw_err_o !== 1'b0) begin n_fail++; $display("FAIL err_clears: got %b want 0", i_rw_err_o); end
        do_req(64'h0000_1000, 1'b0, lat, d, e);
        n_cmp++; if (lat !== 0 || e !== 1'b1) begin n_fail++; $display("FAIL err_range_low: got lat %0d err %b want 0/1", lat, e); end
        @(negedge clk);
        do_req(64'h7FFF_FFF0, 1'b0, lat, d, e);
        n_cmp++; if (lat !== 0 || e !== 1'b1) begin n_fail++; $display("FAIL err_below_base: got lat %0d err %b want 0/1", lat, e); end
        @(negedge clk);
        do_req(64'h8800_0000, 1'b0, lat, d, e);
        n_cmp++; if (lat !== 0 || e !== 1'b1 || d !== 128'h0) begin n_fail++; $display("FAIL err_range_top: got lat %0d err %b data %h want 0/1/0", lat, e, d); end
        @(negedge clk);
        n_cmp++; if (rvalid_cnt - v0 !== 0) begin n_fail++; $display("FAIL err_no_backing: got %0d rvalid cycles want 0", rvalid_cnt - v0); end
        do_req(64'h87FF_FFF8, 1'b0, lat, d, e);
        n_cmp++; if (lat !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL last_line_legal: got lat %0d err %b want 2/0", lat, e); end
        n_cmp++; if (d !== {64'h7800_0007_87FF_FFF8, 64'h7800_000F_87FF_FFF0}) begin n_fail++; $display("FAIL last_line_data: got %h", d); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1; int lat2; logic [127:0] d1; logic [127:0] d2; int b0; int r0;
        mem_delay = 0;
        b0 = beats; r0 = ready_cnt;
        lat1 = -1; lat2 = -1; d1 = '0; d2 = '0;
        i_rw_addr_i = 64'h8000_0000; i_rw_req_i = 1'b0; i_rw_valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_rw_ready_o) begin lat1 = k; d1 = i_data_read_o; break; end
        end
        i_rw_addr_i = 64'h8000_0010;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_rw_ready_o) begin lat2 = k; d2 = i_data_read_o; break; end
        end
        i_rw_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (lat1 !== 2) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 2", lat1); end
        n_cmp++; if (d1 !== 128'h0000_0000_0000_2222_0000_0000_0000_1111) begin n_fail++; $display("FAIL b2b_data1: got %h", d1); end
        n_cmp++; if (lat2 !== 3) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 3", lat2); end
        n_cmp++; if (d2 !== {64'h7FFF_FFE7_8000_0018, 64'h7FFF_FFEF_8000_0010}) begin n_fail++; $display("FAIL b2b_data2: got %h", d2); end
        n_cmp++; if (beats - b0 !== 4) begin n_fail++; $display("FAIL b2b_beats: got %0d want 4", beats - b0); end
        n_cmp++; if (ready_cnt - r0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", ready_cnt - r0); end
    endtask

    task automatic test_flush();
        int lat; logic [127:0] d; logic e; int b0; int r0; int v0; logic seen_hi;
        mem_delay = 3;
        b0 = beats; r0 = ready_cnt; seen_hi = 1'b0;
        i_rw_addr_i = 64'h8000_0040; i_rw_req_i = 1'b0; i_rw_valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_rvalid_o && mem_raddr_o == 64'h8000_0048) begin seen_hi = 1'b1; break; end
        end
        i_rw_valid_i = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++; if (seen_hi !== 1'b1) begin n_fail++; $display("FAIL flush_reach_hi: got %b want 1", seen_hi); end
        n_cmp++; if (ready_cnt - r0 !== 0) begin n_fail++; $display("FAIL flush_no_pulse: got %0d want 0", ready_cnt - r0); end
        n_cmp++; if (beats - b0 !== 2) begin n_fail++; $display("FAIL flush_beats: got %0d want 2", beats - b0); end
        n_cmp++; if (mem_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got rvalid %b want 0", mem_rvalid_o); end
        mem_delay = 0;
        v0 = rvalid_cnt;
        do_req(64'h8000_0040, 1'b0, lat, d, e);
        @(negedge clk);
`ifdef IFU_LINE_BUF_EN
        n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL refetch_hit_latency: got %0d want 0", lat); end
        n_cmp++; if (rvalid_cnt - v0 !== 0) begin n_fail++; $display("FAIL refetch_hit_backing: got %0d want 0", rvalid_cnt - v0); end
`else
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL refetch_latency: got %0d want 2", lat); end
        n_cmp++; if (rvalid_cnt - v0 !== 2) begin n_fail++; $display("FAIL refetch_backing: got %0d want 2", rvalid_cnt - v0); end
`endif
        n_cmp++; if (d !== {64'h7FFF_FFB7_8000_0048, 64'h7FFF_FFBF_8000_0040} || e !== 1'b0) begin n_fail++; $display("FAIL refetch_data: got %h err %b", d, e); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [127:0] d; logic e; int r0;
        mem_delay = 10;
        r0 = ready_cnt;
        i_rw_addr_i = 64'h8000_0030; i_rw_req_i = 1'b0; i_rw_valid_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rvalid_before: got %b want 1", mem_rvalid_o); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (mem_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async_rvalid: got %b want 0", mem_rvalid_o); end
        n_cmp++; if (mem_raddr_o !== 64'h0) begin n_fail++; $display("FAIL rst_mid_async_raddr: got %h want 0", mem_raddr_o); end
        i_rw_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (ready_cnt - r0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_pulse: got %0d want 0", ready_cnt - r0); end
        mem_delay = 0;
        do_req(64'h8000_0040, 1'b0, lat, d, e);
        @(negedge clk);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 2", lat); end
        n_cmp++; if (d !== {64'h7FFF_FFB7_8000_0048, 64'h7FFF_FFBF_8000_0040} || e !== 1'b0) begin n_fail++; $display("FAIL rst_after_data: got %h err %b", d, e); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_slow_mem();
        test_error();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_line_responder.md
Name: ifu_line_responder

Overview:
- Memory-side responder for the IFU instruction-fetch port: the other end of the i_rw_addr/i_rw_req/i_rw_valid/i_data_read/i_rw_ready interface.
- Accepts one 128-bit line request at a time and fetches it as two 64-bit beats over a narrow backing-memory read handshake.
- Returns the assembled line with a one-cycle ready pulse.
- Sits between the core top and the memory model (DPI pmem bridge or SoC bus).

Parameters:
- ADDR_W, 64, address width of both ports.
- MEM_BASE, 64'h8000_0000, first legal byte address.
- MEM_SIZE, 64'h0800_0000, legal range size in bytes; legal when MEM_BASE <= addr < MEM_BASE+MEM_SIZE.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_rw_addr_i  in  ADDR_W  fetch byte address from IFU; bits [3:0] ignored (16-byte aligned line).
- i_rw_req_i  in  1  0 = read, 1 = write (unsupported, answered with error).
- i_rw_valid_i  in  1  request valid, sampled in IDLE only.
- i_data_read_o  out  128  line data; bits [63:0] = addr+0, bits [127:64] = addr+8; meaningful only while i_rw_ready_o=1.
- i_rw_ready_o  out  1  one-cycle response pulse.
- i_rw_err_o  out  1  qualifies i_rw_ready_o: write request or out-of-range address.
- mem_raddr_o  out  ADDR_W  backing read address, 8-byte aligned.
- mem_rvalid_o  out  1  backing read request.
- mem_rdata_i  in  64  backing read data, valid when mem_rready_i=1.
- mem_rready_i  in  1  backing read done; may be asserted in the same cycle mem_rvalid_o rises.

Behaviour:
- Reset (rst=0, async): state=IDLE. i_rw_ready_o=0, i_rw_err_o=0, i_data_read_o=0, mem_rvalid_o=0, mem_raddr_o=0, abort flag cleared.
- Reset mid-transaction discards the transaction; no ready pulse follows.
- FSM states: IDLE, RD_LO, RD_HI, RESP.
- IDLE, i_rw_valid_i=1:
  - Latch line = {addr[ADDR_W-1:4],4'b0}.
  - If req=1 or address illegal: go to RESP with err=1 and data=0; no backing access.
  - Else go to RD_LO.
- RD_LO: mem_rvalid_o=1, mem_raddr_o=line. On mem_rready_i=1, capture low beat and go to RD_HI.
- RD_HI: mem_rvalid_o=1, mem_raddr_o=line+8. On mem_rready_i=1, capture high beat and go to RESP.
- mem_rvalid_o and mem_raddr_o stay stable until mem_rready_i. mem_rdata_i is ignored when mem_rready_i=0.
- RESP: i_rw_ready_o=1 for exactly this cycle, with i_data_read_o and i_rw_err_o valid. Next state is IDLE unconditionally.
- Minimum miss latency (memory answers same cycle): valid sampled at edge N, ready high in cycle N+3.
- Back-to-back: if IFU holds valid in the IDLE cycle after RESP, that is a new request. No request is accepted while not in IDLE.
- Flush: IFU drops valid during RD_LO/RD_HI → abort flag set. Backing reads still complete. RESP is then skipped (IDLE directly, no ready pulse). The line buffer is still filled if enabled.
- i_data_read_o holds its last value outside RESP. i_rw_err_o=0 outside RESP.
- Address arithmetic: line+8 computed modulo 2^ADDR_W. The range check uses the full line address; a line straddling the top of the range is illegal if line+15 >= MEM_BASE+MEM_SIZE.

Optional Feature:
- Macro: IFU_LINE_BUF_EN.
- Defined: a one-entry line buffer holds {tag=line, data, valid}.
  - Filled on every completed error-free fetch, including aborted ones.
  - IDLE request with req=0 and tag match: go directly to RESP with buffered data; ready in cycle N+1; no backing access.
  - Buffer invalidated by reset and by any req=1 request to the same line.
- Undefined: no buffer; every legal read fetches from backing memory.

Test Plan:
- Miss: valid, addr=0x8000_0004, mem answers immediately with 0x1111 (lo) then 0x2222 (hi) → mem_raddr_o 0x8000_0000 then 0x8000_0008; ready in cycle N+3; data=0x…2222_…1111; err=0.
- Slow memory: mem_rready_i delayed 3 cycles per beat → mem_raddr_o stable during wait; ready at N+9; exactly one pulse.
- Error: req=1 addr=0x8000_0000 → ready at N+1, err=1, data=0, mem_rvalid_o never 1. Same result for addr=0x0000_1000 with req=0.
- Flush: valid drops during RD_HI → no ready pulse; FSM returns to IDLE. With IFU_LINE_BUF_EN, a refetch of the same line gives ready at N+1 with no mem_rvalid_o.
- Reset mid-RD_LO: rst=0 asynchronously → mem_rvalid_o falls without waiting for a clock edge. After release, a new request completes normally.
- Back-to-back: valid held high across RESP with addr 0x8000_0000 then 0x8000_0010 → two ready pulses, four backing beats, correct data each.
